fetch_stage: RTL and testbench

- IF stage of the 5-stage pipeline, directly upstream of the F→D pipeline register.
- Owns the PC and issues in-order instruction-memory requests over a valid/ready interface.
- Buffers returned instructions with their PC and presents instrF/PCF/PCPlus4F/validF to the F→D register.
- Handles stall from hazard control and redirect (taken branch/jump) from execute, dropping stale in-flight responses.

---
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues in-order imem requests under a credit limit and
// buffers returned instructions (with their PCs) for the F->D register.
module fetch_stage #(
  parameter int                    word_width = 32,
  parameter logic [word_width-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stallF,
  input  logic                  redirectE,
  input  logic [word_width-1:0] PCTargetE,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [word_width-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [word_width-1:0] imem_resp_data,
  output logic [word_width-1:0] instrF,
  output logic [word_width-1:0] PCF,
  output logic [word_width-1:0] PCPlus4F,
  output logic                  validF
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [word_width-1:0] word_t;

  word_t         pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d, stale_q, stale_d, bcnt_q, bcnt_d;
  logic [PW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [PW-1:0] b_wr_q, b_wr_d, b_rd_q, b_rd_d;
  word_t         pq_mem  [DEPTH];
  word_t         b_instr [DEPTH];
  word_t         b_pc    [DEPTH];
  logic          accept, keep, pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (DEPTH == 1) ? '0 : PW'(p + PW'(1));
  endfunction

  // Credit covers both in-flight requests and buffered entries, so the buffer never overflows.
  assign imem_req_valid = rst_n && !redirectE &&
                          ((CW+1)'(outst_q) + (CW+1)'(bcnt_q) < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign validF   = (bcnt_q != '0);
  assign instrF   = validF ? b_instr[b_rd_q] : word_t'(32'h0000_0013);
  assign PCF      = validF ? b_pc[b_rd_q] : '0;
  assign PCPlus4F = validF ? PCF + word_t'(4) : '0;

  assign accept = imem_req_valid && imem_req_ready;
  assign keep   = imem_resp_valid && !redirectE && (stale_q == '0);
  assign pop    = validF && !stallF && !redirectE;

  always_comb begin
    pc_d    = pc_q;
    stale_d = stale_q;
    bcnt_d  = bcnt_q;
    pq_wr_d = pq_wr_q;
    pq_rd_d = pq_rd_q;
    b_wr_d  = b_wr_q;
    b_rd_d  = b_rd_q;
    outst_d = outst_q + CW'(accept) - CW'(imem_resp_valid);
    if (redirectE) begin
      // Everything still in flight after this cycle belongs to the old path.
      pc_d    = PCTargetE;
      stale_d = outst_d;
      bcnt_d  = '0;
      pq_wr_d = '0;
      pq_rd_d = '0;
      b_wr_d  = '0;
      b_rd_d  = '0;
    end else begin
      if (accept) begin
        pc_d    = pc_q + word_t'(4);
        pq_wr_d = inc(pq_wr_q);
      end
      if (imem_resp_valid && stale_q != '0) stale_d = stale_q - CW'(1);
      if (keep) begin
        pq_rd_d = inc(pq_rd_q);
        b_wr_d  = inc(b_wr_q);
      end
      if (pop) b_rd_d = inc(b_rd_q);
      bcnt_d = bcnt_q + CW'(keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      stale_q <= '0;
      bcnt_q  <= '0;
      pq_wr_q <= '0;
      pq_rd_q <= '0;
      b_wr_q  <= '0;
      b_rd_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      stale_q <= stale_d;
      bcnt_q  <= bcnt_d;
      pq_wr_q <= pq_wr_d;
      pq_rd_q <= pq_rd_d;
      b_wr_q  <= b_wr_d;
      b_rd_q  <= b_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pq_mem[pq_wr_q] <= pc_q;
    if (keep) begin
      b_instr[b_wr_q] <= imem_resp_data;
      b_pc[b_wr_q]    <= pq_mem[pq_rd_q];
    end
  end

  a_resp_credit: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> (outst_q != '0));
endmodule

// File: tb/tb_fetch_stage.sv
// Random-stimulus bench for fetch_stage: a queue-based model of the fetch stream
// against a random-latency in-order instruction memory.
module tb_fetch_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stallF = 1'b0, redirectE = 1'b0, imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] PCTargetE = '0, imem_resp_data = '0;
  logic        imem_req_valid, validF;
  logic [31:0] imem_req_addr, instrF, PCF, PCPlus4F;

  fetch_stage #(.word_width(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .redirectE(redirectE),
    .PCTargetE(PCTargetE), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .validF(validF));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int due; } mreq_t;
  typedef struct { logic [31:0] pc; bit stale; } infl_t;

  mreq_t       mq[$];
  infl_t       inf[$];
  logic [31:0] bq[$];
  logic [31:0] m_pc;
  int          cyc = 0, last_due = 0;
  int          n_cmp = 0, n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_resp_valid = 1'b0; redirectE = 1'b0;
    stallF = 1'b0; imem_req_ready = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_validF",    32'(validF), 32'd0);
    chk("rst_instrF",    instrF, 32'h0000_0013);
    chk("rst_PCF",       PCF, 32'd0);
    chk("rst_PCPlus4F",  PCPlus4F, 32'd0);
    m_pc = 32'h0;
    inf.delete(); bq.delete(); mq.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); cyc++;
    last_due = cyc;
  endtask

  task automatic step(input int p_stall, input int p_redir, input int p_nrdy, input int maxlat);
    bit          exp_rv, acc, dropped, pop;
    logic [31:0] eh;
    int          d;
    infl_t       f;
    @(negedge clk);
    stallF         = ($urandom_range(0, 99) < p_stall);
    redirectE      = ($urandom_range(0, 99) < p_redir);
    PCTargetE      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 1023)) << 2);
    imem_req_ready = ($urandom_range(0, 99) >= p_nrdy);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mq[0].data;
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    #1;
    exp_rv = !redirectE && (inf.size() + bq.size() < DEPTH);
    eh     = (bq.size() > 0) ? bq[0] : 32'h0;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("validF", 32'(validF), 32'(bq.size() > 0));
    chk("instrF", instrF, (bq.size() > 0) ? mem_word(eh) : 32'h0000_0013);
    chk("PCF", PCF, eh);
    chk("PCPlus4F", PCPlus4F, (bq.size() > 0) ? eh + 32'd4 : 32'h0);

    // Memory follows the handshake it actually sees on the bus.
    if (imem_req_valid && imem_req_ready) begin
      d = cyc + $urandom_range(1, maxlat);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{data: mem_word(imem_req_addr), due: d});
    end

    acc     = exp_rv && imem_req_ready;
    pop     = (bq.size() > 0) && !stallF && !redirectE;
    dropped = 1'b1;
    f       = '{pc: 32'h0, stale: 1'b1};
    if (imem_resp_valid) begin
      if (inf.size() == 0) chk("resp_inflight", 32'(inf.size()), 32'd1);
      else begin
        f = inf.pop_front();
        dropped = f.stale || redirectE;
      end
    end
    if (redirectE) begin
      bq.delete();
      foreach (inf[i]) inf[i].stale = 1'b1;
      m_pc = PCTargetE;
    end else begin
      if (pop) void'(bq.pop_front());
      if (imem_resp_valid && !dropped) bq.push_back(f.pc);
      if (acc) begin
        inf.push_back('{pc: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk); cyc++;
  endtask

  initial begin
    do_reset();
    repeat (40)  step(0, 0, 0, 1);
    repeat (300) step(30, 5, 20, 3);
    do_reset();
    repeat (300) step(50, 10, 30, 4);
    repeat (10)  step(0, 0, 0, 1);
    do_reset();
    repeat (200) step(20, 3, 10, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
